mul_nnbit_shift_arb: RTL
========================

// Module: mul_nnbit_shift_arb
// PURPOSE
//   Round-robin arbiter + sequencer sharing one iterative radix-2 signed shift-add multiplier
//   among REQ_NUM requesters. Accepts one operand pair per grant, runs DATA_WIDTH shift-add
//   iterations, returns the 2*DATA_WIDTH-bit product tagged with the requester ID over a
//   valid/ready response channel. Sits between client blocks and the multiply datapath in calc/mul.
// PARAMETERS
//   DATA_WIDTH  8  operand width in bits, >= 2; product width is 2*DATA_WIDTH
//   REQ_NUM     4  number of requesters, >= 2
//   ID_WIDTH    $clog2(REQ_NUM)  requester ID width (derived, do not override)
// PORTS
//   i_clk      in   1                     clock, all logic on rising edge
//   i_rst_n    in   1                     synchronous active-low reset
//   i_req_vld  in   REQ_NUM               per-requester request valid
//   i_req_x    in   REQ_NUM*DATA_WIDTH    packed multiplicands, requester k at [k*DW +: DW]
//   i_req_y    in   REQ_NUM*DATA_WIDTH    packed multipliers, same packing
//   o_req_rdy  out  REQ_NUM               one-hot grant/ready; handshake = vld[k] & rdy[k]
//   o_rsp_vld  out  1                     product valid
//   i_rsp_rdy  in   1                     consumer ready for product
//   o_rsp_id   out  ID_WIDTH              index of requester that owns o_rsp_res
//   o_rsp_res  out  2*DATA_WIDTH          signed product x*y, two's complement
//   o_busy     out  1                     high in CALC and DONE
// BEHAVIOUR
//   Reset (i_rst_n low at a rising edge): state IDLE, RR pointer 0, o_rsp_vld 0, o_rsp_id 0,
//     o_rsp_res 0, o_busy 0, iteration counter 0; o_req_rdy all 0 while i_rst_n low.
//     Reset mid-CALC/DONE abandons the operation; no response is ever produced for it.
//   FSM: IDLE -> CALC on request handshake; CALC -> DONE after DATA_WIDTH iterations;
//     DONE -> IDLE on o_rsp_vld & i_rsp_rdy. No other transitions.
//   Arbitration (IDLE only): grantee = first k with i_req_vld[k]=1 scanning k = ptr, ptr+1, ...
//     modulo REQ_NUM; o_req_rdy = onehot(grantee), combinational from i_req_vld; all 0 if no
//     vld or state != IDLE. On handshake: latch x sign-extended to 2*DW, y, ID; ptr <= (g+1)%REQ_NUM.
//     Pointer changes only on handshake.
//   Datapath: accumulator cleared on accept. CALC iteration i (0..DW-1): if y[i], acc += x<<i for
//     i < DW-1, acc -= x<<(DW-1) for i = DW-1 (multiplier MSB weight negative). All arithmetic
//     modulo 2^(2*DW). Result equals signed(x)*signed(y) exactly for all inputs incl. -2^(DW-1)^2.
//   Latency: handshake in cycle T -> o_rsp_vld first high in cycle T+DATA_WIDTH+1.
//   DONE: o_rsp_vld=1; o_rsp_res, o_rsp_id held stable until response handshake; o_rsp_vld drops
//     the cycle after the handshake. Earliest next grant: cycle after handshake (IDLE).
//     Minimum initiation interval DATA_WIDTH+2 cycles.
//   o_rsp_res/o_rsp_id retain last value outside DONE (not required to clear); only o_rsp_vld qualifies.
//   Requesters may drop i_req_vld without handshake; operands sampled only on the handshake edge.
// TESTING
//   1. DW=8: req0 x=-3 (8'hFD), y=5 -> o_rsp_res=16'hFFF1, id=0, vld high exactly 9 cycles after accept.
//   2. x=8'h80, y=8'h80 -> 16'h4000; x=8'h80, y=8'h7F -> 16'hC080; x=0,y=8'hFF -> 16'h0000.
//   3. All 4 vld held high, i_rsp_rdy=1 -> grant order 0,1,2,3,0; ids match; each result correct.
//   4. ptr=1, only vld[0] and vld[2] high -> grant 2, then ptr=3 -> grant 0.
//   5. i_rsp_rdy low 5 cycles in DONE -> vld/res/id stable, o_req_rdy all 0, no new accept.
//   6. i_rst_n low for 1 cycle during CALC iteration 4 -> no response, IDLE, ptr 0; next req ok.
//   Plus random self-check vs. $signed reference model, 10k ops, random vld/rdy backpressure.

Source files
------------

// File: rtl/mul_nnbit_shift_arb.sv
// Round-robin arbiter in front of one iterative radix-2 signed shift-add multiplier.
// One operand pair per grant; the product returns tagged with the requester ID.
module mul_nnbit_shift_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int REQ_NUM    = 4,
  parameter int ID_WIDTH   = $clog2(REQ_NUM)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [REQ_NUM-1:0]            i_req_vld,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_x,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] i_req_y,
  output logic [REQ_NUM-1:0]            o_req_rdy,
  output logic                          o_rsp_vld,
  input  logic                          i_rsp_rdy,
  output logic [ID_WIDTH-1:0]           o_rsp_id,
  output logic [2*DATA_WIDTH-1:0]       o_rsp_res,
  output logic                          o_busy
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [ID_WIDTH-1:0]   r_ptr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   r_rsp_id;
  logic [PW-1:0]         r_acc;
  logic [PW-1:0]         r_xs;
  logic [PW-1:0]         r_rsp_res;
  logic [DATA_WIDTH-1:0] r_ys;
  logic [CW-1:0]         r_cnt;
  logic                  r_rsp_vld;

  logic [REQ_NUM-1:0]    w_rot;
  logic [REQ_NUM-1:0]    w_rdy;
  logic [ID_WIDTH-1:0]   w_off;
  logic [ID_WIDTH-1:0]   w_gnt;
  logic [ID_WIDTH-1:0]   w_ptr_nxt;
  logic [ID_WIDTH:0]     w_sum;
  logic                  w_any;
  logic                  w_hs;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_x;
  logic [DATA_WIDTH-1:0] w_y;
  logic [PW-1:0]         w_term;
  logic [PW-1:0]         w_acc_nxt;

  // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    w_rot = REQ_NUM'({i_req_vld, i_req_vld} >> r_ptr);
    w_any = |w_rot;
    w_off = '0;
    for (int j = REQ_NUM - 1; j >= 0; j--) begin
      w_off = w_rot[j] ? ID_WIDTH'(j) : w_off;
    end
    w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    w_gnt     = (w_sum >= (ID_WIDTH+1)'(REQ_NUM)) ?
                ID_WIDTH'(w_sum - (ID_WIDTH+1)'(REQ_NUM)) : w_sum[ID_WIDTH-1:0];
    w_ptr_nxt = (w_gnt == ID_WIDTH'(REQ_NUM - 1)) ? '0 : w_gnt + ID_WIDTH'(1);
    w_rdy     = (w_any && (r_state == S_IDLE) && i_rst_n) ? (REQ_NUM'(1) << w_gnt) : '0;
    w_hs      = |(w_rdy & i_req_vld);
  end

  // Operand select for the grantee.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      w_x = (w_gnt == ID_WIDTH'(k)) ? i_req_x[k*DATA_WIDTH +: DATA_WIDTH] : w_x;
      w_y = (w_gnt == ID_WIDTH'(k)) ? i_req_y[k*DATA_WIDTH +: DATA_WIDTH] : w_y;
    end
  end

  // The multiplier MSB carries negative weight, so the last step subtracts.
  always_comb begin
    w_last    = (r_cnt == CW'(DATA_WIDTH - 1));
    w_term    = r_ys[0] ? r_xs : '0;
    w_acc_nxt = w_last ? (r_acc - w_term) : (r_acc + w_term);
  end

  // Sequencer FSM, pointer and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_rsp_id  <= '0;
      r_acc     <= '0;
      r_xs      <= '0;
      r_ys      <= '0;
      r_cnt     <= '0;
      r_rsp_res <= '0;
      r_rsp_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_state <= S_CALC;
            r_xs    <= {{DATA_WIDTH{w_x[DATA_WIDTH-1]}}, w_x};
            r_ys    <= w_y;
            r_id    <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_xs  <= r_xs << 1;
          r_ys  <= r_ys >> 1;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_state   <= S_DONE;
            r_rsp_vld <= 1'b1;
            r_rsp_res <= w_acc_nxt;
            r_rsp_id  <= r_id;
          end else begin
            r_acc <= w_acc_nxt;
          end
        end
        S_DONE: begin
          if (i_rsp_rdy) begin
            r_state   <= S_IDLE;
            r_rsp_vld <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rsp_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_rdy = w_rdy;
  assign o_rsp_vld = r_rsp_vld;
  assign o_rsp_id  = r_rsp_id;
  assign o_rsp_res = r_rsp_res;
  assign o_busy    = (r_state != S_IDLE);

endmodule
